// File: rtl/inst_prefetch_pkg.sv
// inst_prefetch_pkg
//   Shared definitions for the instruction prefetch unit:
//   - INST_W            : instruction / address width (32)
//   - RESET_PC_DEFAULT  : default first fetch address after reset
//   - pf_state_e        : fetch FSM states (IDLE, RUN, DRAIN)
//   - pf_entry_t        : 64-bit queue entry {pc, word}
//   - word_align()      : forces an address onto a 4-byte boundary
package inst_prefetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_RUN   = 2'd1,
    PF_DRAIN = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] word;
  } pf_entry_t;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return addr & ~INST_W'(3);
  endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// pf_fifo
//   Synchronous FIFO of {pc, inst} entries used as the prefetch queue.
//   The head entry is presented combinationally; it only changes on pop,
//   so it stays stable while the consumer stalls.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           drop all entries (pointers and count to zero)
//   push, push_data write one entry (caller guarantees not full)
//   pop             retire the head entry (caller guarantees not empty)
//   head            current head entry
//   count           occupancy, 0..DEPTH
module pf_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  pf_entry_t              push_data,
  input  logic                   pop,
  output pf_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  // Storage carries no reset: entries are only visible while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch
//   Instruction prefetch unit: issues one ROM read at a time, queues the
//   returned words with their byte addresses, and hands them to decode.
//   A redirect flushes the queue and restarts fetching at redirect_pc;
//   a read still in flight at that moment is completed and discarded
//   (DRAIN state) so the ROM handshake is never abandoned.
// Parameters:
//   DEPTH     queue entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   rom_req, rom_addr          ROM read request / byte address (registered)
//   rom_ack, rom_data          ROM read completion / returned word
//   inst_valid, inst, inst_pc  queue head towards decode
//   inst_ready                 decode consumes the head
//   redirect, redirect_pc      taken branch and its target
// Configuration:
//   INST_PREFETCH_BYPASS_EN    when defined, a word returned into an empty
//                              queue with inst_ready=1 is forwarded to
//                              inst/inst_pc in the ack cycle instead of
//                              being queued.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_req,
  output logic [INST_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = PF_IDLE;
  localparam logic [1:0] S_RUN   = PF_RUN;
  localparam logic [1:0] S_DRAIN = PF_DRAIN;

  logic [1:0]        state_reg,      state_next;
  logic [INST_W-1:0] fetch_pc_reg,   fetch_pc_next;
  logic [INST_W-1:0] drain_addr_reg, drain_addr_next;

  logic [CW-1:0]     fifo_count;
  pf_entry_t         fifo_head;
  pf_entry_t         push_entry;
  logic              fifo_valid;
  logic              ack_run;
  logic              bypass;
  logic              push;
  logic              pop;

  // rom_req depends on state and queue occupancy only. While it is high
  // the occupancy can only fall (push needs an ack), so the request stays
  // asserted until acknowledged.
  assign rom_req    = (state_reg == S_DRAIN) |
                      ((state_reg == S_RUN) & (fifo_count < DEPTH_C));
  // In DRAIN the address of the read being discarded must stay on the bus
  // even though fetch_pc already points at the redirect target.
  assign rom_addr   = (state_reg == S_DRAIN) ? drain_addr_reg : fetch_pc_reg;

  assign fifo_valid = (fifo_count != '0);
  assign ack_run    = (state_reg == S_RUN) & rom_req & rom_ack;

`ifdef INST_PREFETCH_BYPASS_EN
  assign bypass     = ack_run & ~redirect & ~fifo_valid & inst_ready;
`else
  assign bypass     = 1'b0;
`endif

  // Redirect wins over both queue operations.
  assign push       = ack_run & ~redirect & ~bypass;
  assign pop        = fifo_valid & inst_ready & ~redirect;
  assign push_entry = '{pc: fetch_pc_reg, word: rom_data};

  pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    drain_addr_next = drain_addr_reg;

    if (redirect) begin
      fetch_pc_next = word_align(redirect_pc);
    end else if (ack_run) begin
      fetch_pc_next = fetch_pc_reg + INST_W'(4);
    end

    case (state_reg)
      S_IDLE: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        // A redirect with a read in flight must wait for that read's ack.
        if (redirect && rom_req && !rom_ack) begin
          state_next      = S_DRAIN;
          drain_addr_next = fetch_pc_reg;
        end
      end
      S_DRAIN: begin
        if (rom_ack) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      drain_addr_reg <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      drain_addr_reg <= drain_addr_next;
    end
  end

  always_comb begin
    inst_valid = fifo_valid;
    inst       = fifo_valid ? fifo_head.word : '0;
    inst_pc    = fifo_valid ? fifo_head.pc   : '0;
`ifdef INST_PREFETCH_BYPASS_EN
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = rom_data;
      inst_pc    = fetch_pc_reg;
    end
`endif
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch-queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 rom_req  out  1  instruction-ROM read request.
REQ-006 rom_addr  out  32  byte address of the pending ROM read.
REQ-007 rom_ack  in  1  ROM read complete; rom_data valid this cycle.
REQ-008 rom_data  in  32  instruction word returned by the ROM.
REQ-009 inst_valid  out  1  queue head holds a valid instruction.
REQ-010 inst  out  32  queue-head instruction word.
REQ-011 inst_pc  out  32  byte address of inst.
REQ-012 inst_ready  in  1  downstream decode/control consumes the head when inst_valid=1.
REQ-013 redirect  in  1  taken branch; flush the queue and refetch.
REQ-014 redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; IDLE->RUN on the first clock edge after rst deasserts.
REQ-016 rom_req = (state==DRAIN) | (state==RUN & count<DEPTH); it is driven from registers only, with no combinational path from inputs.
REQ-017 Once rom_req is high, rom_req and rom_addr hold stable until the cycle rom_ack=1; only one read is outstanding at a time.
REQ-018 RUN, rom_ack=1, redirect=0: push {fetch_pc, rom_data}; fetch_pc += 4, wrapping modulo 2^32 (FFFF_FFFC -> 0000_0000).
REQ-019 Pop occurs when inst_valid & inst_ready; a simultaneous push and pop leaves count unchanged.
REQ-020 Push never occurs when count==DEPTH, because no request is issued while the queue is full.
REQ-021 Redirect has priority over push and pop: queue cleared (count=0), fetch_pc <= {redirect_pc[31:2],2'b00}, and the head is not consumed that cycle.
REQ-022 Redirect with a read outstanding and rom_ack=0: go to DRAIN; the old rom_addr stays asserted.
REQ-023 Redirect in the same cycle as rom_ack=1: rom_data is discarded and the FSM stays in or returns to RUN.
REQ-024 DRAIN: on rom_ack, discard rom_data and go to RUN; a redirect during DRAIN updates fetch_pc and the FSM stays in DRAIN.
REQ-025 Latency without bypass: rom_ack in cycle N gives inst_valid=1 in cycle N+1.
REQ-026 inst and inst_pc stay stable while inst_valid=1 and inst_ready=0.

Reset
REQ-027 While rst=0: state=IDLE, fetch_pc=RESET_PC, count=0, rom_req=0, rom_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
REQ-028 Asserting rst mid-transaction abandons the outstanding read; a rom_ack arriving after reset release while in IDLE is ignored.

Configuration
REQ-029 Macro INST_PREFETCH_BYPASS_EN defined: when count==0, state==RUN, rom_ack=1, redirect=0 and inst_ready=1, rom_data/rom_addr appear on inst/inst_pc with inst_valid=1 in the same cycle and are not pushed.
REQ-030 Macro undefined: no combinational path from rom_* to inst_*; REQ-025 latency applies in all cases.

Structure
REQ-031 Package inst_prefetch_pkg holds the state enum, INST_W=32 and the default RESET_PC constant.
REQ-032 Sub-module pf_fifo is a synchronous FIFO of 64-bit {pc,inst} entries with DEPTH entries, an occupancy count, and a clear input; inst_prefetch instantiates it once.

Verification
REQ-033 Reset release, ROM ack latency 0 cycles, inst_ready=1: rom_addr sequence 0,4,8,...; inst_pc follows one cycle behind each ack.
REQ-034 inst_ready=0, DEPTH=4: after 4 acks rom_req=0; one pop -> rom_req=1 next cycle with rom_addr=0x10.
REQ-035 ROM ack latency 3; redirect to 0x0000_0103 in the 2nd wait cycle -> DRAIN; returned data dropped; next rom_addr=0x0000_0100; inst_valid stays 0 until that read is acked.
REQ-036 Redirect coincident with rom_ack and inst_ready, count=2 -> count=0, no push and no pop, next rom_addr=redirect target.
REQ-037 Redirect to 0xFFFF_FFF8 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst pulled low during a ROM wait, then released -> all outputs at reset values; first request to RESET_PC in RUN; with INST_PREFETCH_BYPASS_EN and an empty queue, the ack cycle shows inst_valid=1.
